// File: rtl/sync_fifo_wm_if.sv
// Valid/ready handshake bundle for sync_fifo_wm: producer push side and consumer pop side.
interface sync_fifo_wm_if #(
    parameter int FIFO_W = 32
);
    logic              push_vld;
    logic              push_rdy;
    logic [FIFO_W-1:0] push_dat;
    logic              pop_vld;
    logic              pop_rdy;
    logic [FIFO_W-1:0] pop_dat;

    modport master (
        output push_vld, push_dat, pop_rdy,
        input  push_rdy, pop_vld, pop_dat
    );

    modport slave (
        input  push_vld, push_dat, pop_rdy,
        output push_rdy, pop_vld, pop_dat
    );
endinterface

// File: rtl/sync_fifo_wm.sv
// Single-clock FWFT FIFO, any depth >= 2, with watermarks, high-water mark and sticky errors.
// Define SYNC_FIFO_WM_ERR_EN to build the sticky overflow/underflow flags; otherwise they read 0.
module sync_fifo_wm #(
    parameter int   FIFO_D   = 12,
    parameter int   FIFO_W   = 32,
    localparam int  FIFO_ADR = $clog2(FIFO_D)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              fifo_fsh,
    sync_fifo_wm_if.slave     bus,
    input  logic [FIFO_ADR:0] afull_thr,
    input  logic [FIFO_ADR:0] aempt_thr,
    output logic [FIFO_ADR:0] fifo_len,
    output logic              fifo_full,
    output logic              fifo_empt,
    output logic              fifo_afull,
    output logic              fifo_aempt,
    output logic [FIFO_ADR:0] fifo_maxlen,
    input  logic              err_clr,
    output logic              fifo_ovf,
    output logic              fifo_udf
);
    localparam logic [FIFO_ADR-1:0] PTR_LAST = FIFO_ADR'(FIFO_D - 1);
    localparam logic [FIFO_ADR-1:0] PTR_ONE  = FIFO_ADR'(1);
    localparam logic [FIFO_ADR:0]   LEN_FULL = (FIFO_ADR + 1)'(FIFO_D);
    localparam logic [FIFO_ADR:0]   LEN_ONE  = (FIFO_ADR + 1)'(1);

    logic [FIFO_W-1:0]   mem_q [FIFO_D];
    logic [FIFO_ADR-1:0] wr_ptr_q, wr_ptr_d;
    logic [FIFO_ADR-1:0] rd_ptr_q, rd_ptr_d;
    logic [FIFO_ADR:0]   len_q, len_d;
    logic [FIFO_ADR:0]   maxlen_q, maxlen_d;
    logic                push_acc, pop_acc;

    // Explicit wrap so non-power-of-two depths never address past the last entry.
    function automatic logic [FIFO_ADR-1:0] ptr_inc(input logic [FIFO_ADR-1:0] p);
        return (p == PTR_LAST) ? '0 : p + PTR_ONE;
    endfunction

    assign fifo_full   = (len_q == LEN_FULL);
    assign fifo_empt   = (len_q == '0);
    assign fifo_afull  = (len_q >= afull_thr);
    assign fifo_aempt  = (len_q <= aempt_thr);
    assign fifo_len    = len_q;
    assign fifo_maxlen = maxlen_q;

    assign bus.push_rdy = ~fifo_full;
    assign bus.pop_vld  = ~fifo_empt;
    assign bus.pop_dat  = mem_q[rd_ptr_q];

    assign push_acc = bus.push_vld & ~fifo_full;
    assign pop_acc  = bus.pop_rdy & ~fifo_empt;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        len_d    = len_q;
        maxlen_d = maxlen_q;
        if (fifo_fsh) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            len_d    = '0;
            maxlen_d = '0;
        end else begin
            if (push_acc) wr_ptr_d = ptr_inc(wr_ptr_q);
            if (pop_acc)  rd_ptr_d = ptr_inc(rd_ptr_q);
            if (push_acc && !pop_acc)      len_d = len_q + LEN_ONE;
            else if (!push_acc && pop_acc) len_d = len_q - LEN_ONE;
            // A new maximum in the same cycle takes precedence over err_clr.
            if (len_d > maxlen_q) maxlen_d = len_d;
            else if (err_clr)     maxlen_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            len_q    <= '0;
            maxlen_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            len_q    <= len_d;
            maxlen_q <= maxlen_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push_acc && !fifo_fsh) mem_q[wr_ptr_q] <= bus.push_dat;
    end

`ifdef SYNC_FIFO_WM_ERR_EN
    logic ovf_q, ovf_d;
    logic udf_q, udf_d;

    always_comb begin
        ovf_d = ovf_q & ~err_clr;
        udf_d = udf_q & ~err_clr;
        if (bus.push_vld && fifo_full) ovf_d = 1'b1;
        if (bus.pop_rdy && fifo_empt)  udf_d = 1'b1;
        // Requests in a flush cycle are discarded, so they never raise an error.
        if (fifo_fsh) begin
            ovf_d = 1'b0;
            udf_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ovf_q <= 1'b0;
            udf_q <= 1'b0;
        end else begin
            ovf_q <= ovf_d;
            udf_q <= udf_d;
        end
    end

    assign fifo_ovf = ovf_q;
    assign fifo_udf = udf_q;
`else
    assign fifo_ovf = 1'b0;
    assign fifo_udf = 1'b0;
`endif
endmodule

// File: tb/tb_sync_fifo_wm.sv
// Directed bench for sync_fifo_wm (FIFO_D=12): fill/drain, wrap, full push+pop, watermarks, flush, errors, reset.
module tb_sync_fifo_wm;
    localparam int D = 12;
    localparam int W = 32;
    localparam int A = $clog2(D);
`ifdef SYNC_FIFO_WM_ERR_EN
    localparam logic ERR = 1'b1;
`else
    localparam logic ERR = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         rst;
    logic         fifo_fsh;
    logic         err_clr;
    logic [A:0]   afull_thr;
    logic [A:0]   aempt_thr;
    logic [A:0]   fifo_len;
    logic [A:0]   fifo_maxlen;
    logic         fifo_full, fifo_empt, fifo_afull, fifo_aempt;
    logic         fifo_ovf, fifo_udf;
    int           n_tests = 0;
    int           n_fail  = 0;

    sync_fifo_wm_if #(.FIFO_W(W)) bus ();

    sync_fifo_wm #(.FIFO_D(D), .FIFO_W(W)) dut (
        .clk         (clk),
        .rst         (rst),
        .fifo_fsh    (fifo_fsh),
        .bus         (bus),
        .afull_thr   (afull_thr),
        .aempt_thr   (aempt_thr),
        .fifo_len    (fifo_len),
        .fifo_full   (fifo_full),
        .fifo_empt   (fifo_empt),
        .fifo_afull  (fifo_afull),
        .fifo_aempt  (fifo_aempt),
        .fifo_maxlen (fifo_maxlen),
        .err_clr     (err_clr),
        .fifo_ovf    (fifo_ovf),
        .fifo_udf    (fifo_udf)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_reset_state(input string tag);
        chk({tag, "_push_rdy"}, 32'(bus.push_rdy), 32'd1);
        chk({tag, "_pop_vld"},  32'(bus.pop_vld),  32'd0);
        chk({tag, "_len"},      32'(fifo_len),     32'd0);
        chk({tag, "_full"},     32'(fifo_full),    32'd0);
        chk({tag, "_empt"},     32'(fifo_empt),    32'd1);
        chk({tag, "_maxlen"},   32'(fifo_maxlen),  32'd0);
        chk({tag, "_ovf"},      32'(fifo_ovf),     32'd0);
        chk({tag, "_udf"},      32'(fifo_udf),     32'd0);
        chk({tag, "_afull"},    32'(fifo_afull),   32'd0);
        chk({tag, "_aempt"},    32'(fifo_aempt),   32'd1);
    endtask

    initial begin
        rst          = 1'b1;
        fifo_fsh     = 1'b0;
        err_clr      = 1'b0;
        afull_thr    = (A + 1)'(10);
        aempt_thr    = (A + 1)'(2);
        bus.push_vld = 1'b0;
        bus.push_dat = '0;
        bus.pop_rdy  = 1'b0;
        step();
        step();
        chk_reset_state("rst");
        rst = 1'b0;

        // Fill 0x0..0xB with no pops; watermark edges checked along the way.
        for (int i = 0; i < D; i++) begin
            bus.push_vld = 1'b1;
            bus.push_dat = 32'(i);
            step();
            chk("fill_len",   32'(fifo_len),   32'(i + 1));
            chk("fill_afull", 32'(fifo_afull), 32'((i + 1) >= 10));
            chk("fill_aempt", 32'(fifo_aempt), 32'((i + 1) <= 2));
            if (i == 0) begin
                chk("latency_pop_vld", 32'(bus.pop_vld), 32'd1);
                chk("latency_pop_dat", bus.pop_dat,      32'h0);
            end
        end
        chk("full_flag",     32'(fifo_full),    32'd1);
        chk("full_push_rdy", 32'(bus.push_rdy), 32'd0);
        chk("full_maxlen",   32'(fifo_maxlen),  32'd12);

        // Full with simultaneous push and pop: push refused, head popped.
        bus.push_dat = 32'hDEAD;
        bus.pop_rdy  = 1'b1;
        chk("drain_dat0", bus.pop_dat, 32'h0);
        step();
        bus.push_vld = 1'b0;
        chk("fullpp_len", 32'(fifo_len), 32'd11);
        chk("fullpp_ovf", 32'(fifo_ovf), 32'(ERR));
        for (int i = 1; i < D; i++) begin
            chk("drain_dat", bus.pop_dat, 32'(i));
            step();
        end
        bus.pop_rdy = 1'b0;
        chk("drain_empt",    32'(fifo_empt),   32'd1);
        chk("drain_len",     32'(fifo_len),    32'd0);
        chk("drain_pop_vld", 32'(bus.pop_vld), 32'd0);
        chk("drain_udf",     32'(fifo_udf),    32'd0);

        err_clr = 1'b1;
        step();
        err_clr = 1'b0;
        chk("clr_ovf",    32'(fifo_ovf),    32'd0);
        chk("clr_maxlen", 32'(fifo_maxlen), 32'd0);

        // Wrap-around: prime 5 entries, then push and pop together; 30 words total.
        for (int c = 0; c < 30; c++) begin
            bus.push_vld = 1'b1;
            bus.push_dat = 32'h100 + 32'(c);
            bus.pop_rdy  = (c >= 5);
            if (c >= 5) chk("wrap_dat", bus.pop_dat, 32'h100 + 32'(c - 5));
            step();
            chk("wrap_len", 32'(fifo_len), (c < 5) ? 32'(c + 1) : 32'd5);
        end
        bus.push_vld = 1'b0;
        bus.pop_rdy  = 1'b1;
        for (int k = 0; k < 5; k++) begin
            chk("wrap_tail_dat", bus.pop_dat, 32'h100 + 32'(25 + k));
            step();
        end
        bus.pop_rdy = 1'b0;
        chk("wrap_empt",   32'(fifo_empt),   32'd1);
        chk("wrap_maxlen", 32'(fifo_maxlen), 32'd5);

        // Threshold change takes effect combinationally.
        for (int k = 0; k < 5; k++) begin
            bus.push_vld = 1'b1;
            bus.push_dat = 32'h200 + 32'(k);
            step();
        end
        bus.push_vld = 1'b0;
        chk("wm_afull_hi_thr", 32'(fifo_afull), 32'd0);
        afull_thr = (A + 1)'(4);
        #1;
        chk("wm_afull_lo_thr", 32'(fifo_afull), 32'd1);
        afull_thr = (A + 1)'(10);

        // Flush at len=7 together with a push.
        for (int k = 0; k < 2; k++) begin
            bus.push_vld = 1'b1;
            bus.push_dat = 32'h280 + 32'(k);
            step();
        end
        chk("pre_fsh_len",    32'(fifo_len),    32'd7);
        chk("pre_fsh_maxlen", 32'(fifo_maxlen), 32'd7);
        fifo_fsh     = 1'b1;
        bus.push_dat = 32'hBAD;
        step();
        fifo_fsh     = 1'b0;
        bus.push_vld = 1'b0;
        chk("fsh_len",     32'(fifo_len),    32'd0);
        chk("fsh_maxlen",  32'(fifo_maxlen), 32'd0);
        chk("fsh_empt",    32'(fifo_empt),   32'd1);
        chk("fsh_ovf",     32'(fifo_ovf),    32'd0);
        chk("fsh_pop_vld", 32'(bus.pop_vld), 32'd0);

        // Underflow, clear, and set-wins-over-clear.
        bus.pop_rdy = 1'b1;
        step();
        bus.pop_rdy = 1'b0;
        chk("udf_set", 32'(fifo_udf), 32'(ERR));
        chk("udf_len", 32'(fifo_len), 32'd0);
        err_clr = 1'b1;
        step();
        err_clr = 1'b0;
        chk("udf_clr", 32'(fifo_udf), 32'd0);
        bus.pop_rdy = 1'b1;
        err_clr     = 1'b1;
        step();
        bus.pop_rdy = 1'b0;
        chk("udf_set_wins", 32'(fifo_udf), 32'(ERR));
        step();
        err_clr = 1'b0;
        chk("udf_clr2", 32'(fifo_udf), 32'd0);

        // Reset mid-stream at len=6 with a push pending.
        for (int k = 0; k < 6; k++) begin
            bus.push_vld = 1'b1;
            bus.push_dat = 32'h300 + 32'(k);
            step();
        end
        chk("pre_rst_len", 32'(fifo_len), 32'd6);
        bus.push_dat = 32'h3FF;
        rst = 1'b1;
        step();
        chk_reset_state("midrst");
        rst          = 1'b0;
        bus.push_dat = 32'h3AA;
        #1;
        chk("post_rst_pop_vld0", 32'(bus.pop_vld), 32'd0);
        step();
        bus.push_vld = 1'b0;
        chk("post_rst_pop_vld1", 32'(bus.pop_vld), 32'd1);
        chk("post_rst_pop_dat",  bus.pop_dat,      32'h3AA);
        chk("post_rst_len",      32'(fifo_len),    32'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
